// File: rtl/frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_rx_pkg
// Brief   : Shared state encoding and default constants for the frame receiver.
// Revision: 1.0 - initial release
// ============================================================================
package frame_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int C_DATA_W  = 8;
  localparam int C_OS      = 4;
  localparam int C_TIMER_W = $clog2(C_OS);

endpackage
`default_nettype wire

// File: rtl/frame_rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module  : bit_timer
// Brief   : Mod-OS bit timer with synchronous clear and mid/end-of-bit ticks.
// Revision: 1.0 - initial release
// ============================================================================
module bit_timer #(
  parameter int OS = 4,
  parameter int TW = $clog2(OS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam logic [TW-1:0] C_HALF = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] C_FULL = TW'(OS - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(negedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == C_FULL) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign half_tick = (r_cnt == C_HALF);
  assign full_tick = (r_cnt == C_FULL);

endmodule
`default_nettype wire

// File: rtl/frame_rx.sv
`default_nettype none
// ============================================================================
// Module  : frame_rx
// Brief   : Oversampling start/data/stop frame receiver, LSB-first, negedge.
// Revision: 1.0 - initial release
// ============================================================================
module frame_rx
  import frame_rx_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int OS     = C_OS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int TW = $clog2(OS);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(DATA_W - 1);

  state_t            r_state;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_frame_err;

  logic w_half_tick;
  logic w_full_tick;
  logic w_timer_clr;

  // Timer is held at zero while idle and restarted when the start bit is confirmed.
  assign w_timer_clr = (r_state == S_IDLE) || ((r_state == S_START) && w_half_tick);

  bit_timer #(
    .OS (OS),
    .TW (TW)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_timer_clr),
    .half_tick (w_half_tick),
    .full_tick (w_full_tick)
  );

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_shreg      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!din) r_state <= S_START;
        end
        S_START: begin
          if (w_half_tick) begin
            r_idx   <= '0;
            r_state <= din ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_full_tick) begin
            r_shreg[r_idx] <= din;
            if (r_idx == C_LAST_IDX) begin
              r_idx   <= '0;
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (w_full_tick) begin
            if (din) begin
              r_dout       <= r_shreg;
              r_dout_valid <= 1'b1;
            end else begin
              r_frame_err  <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_frame_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_rx
// Brief   : Directed self-checking bench for frame_rx at DATA_W=8, OS=4.
// Revision: 1.0 - initial release
// ============================================================================
module tb_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int edge_no = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  int last_valid_edge = -1;
  int last_err_edge = -1;
  logic [7:0] valid_vals[$];

  frame_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Observe outputs 1 time unit after each active (falling) edge.
  always begin
    @(negedge clk);
    #1;
    edge_no = edge_no + 1;
    if (dout_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      last_valid_edge = edge_no;
      valid_vals.push_back(dout);
    end
    if (frame_err === 1'b1) begin
      err_cnt = err_cnt + 1;
      last_err_edge = edge_no;
    end
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    step(4);
  endtask

  // Returns E0, the edge at which the receiver first sees the start bit.
  task automatic send_frame(input logic [7:0] data, input logic stop, output int e0);
    e0 = edge_no + 1;
    send_bit(1'b0);
    for (int k = 0; k < 8; k++) send_bit(data[k]);
    send_bit(stop);
    din = 1'b1;
  endtask

  int e0, e0b, v0, f0, b0, q0;

  initial begin
    rst_n = 1'b0;
    din   = 1'b1;
    step(3);
    check("reset_dout", {24'd0, dout}, 32'h0);
    check("reset_valid", {31'd0, dout_valid}, 32'h0);
    check("reset_ferr", {31'd0, frame_err}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    step(5);

    // Good frame 0xA5
    v0 = valid_cnt; f0 = err_cnt;
    send_frame(8'hA5, 1'b1, e0);
    step(5);
    check("a5_valid_count", valid_cnt - v0, 1);
    check("a5_valid_edge", last_valid_edge - e0, 38);
    check("a5_dout", {24'd0, dout}, 32'hA5);
    check("a5_no_ferr", err_cnt - f0, 0);
    check("a5_busy_idle", {31'd0, busy}, 32'h0);

    // Framing error: stop sampled low, trailing low then looks like a glitch start
    v0 = valid_cnt; f0 = err_cnt;
    send_frame(8'hA5, 1'b0, e0);
    step(10);
    check("ferr_count", err_cnt - f0, 1);
    check("ferr_edge", last_err_edge - e0, 38);
    check("ferr_no_valid", valid_cnt - v0, 0);
    check("ferr_dout_hold", {24'd0, dout}, 32'hA5);
    check("ferr_busy_idle", {31'd0, busy}, 32'h0);

    // Glitch start: one low cycle
    v0 = valid_cnt; f0 = err_cnt;
    din = 1'b0;
    step(1);
    din = 1'b1;
    check("glitch_busy_e0", {31'd0, busy}, 32'h1);
    step(1);
    check("glitch_busy_e1", {31'd0, busy}, 32'h1);
    step(1);
    check("glitch_busy_e2", {31'd0, busy}, 32'h0);
    b0 = busy_cnt;
    step(20);
    check("glitch_busy_stays_low", busy_cnt - b0, 0);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_no_ferr", err_cnt - f0, 0);

    // Back-to-back 0x3C then 0xC3
    v0 = valid_cnt; f0 = err_cnt; q0 = valid_vals.size();
    send_frame(8'h3C, 1'b1, e0);
    send_frame(8'hC3, 1'b1, e0b);
    step(5);
    check("b2b_start_gap", e0b - e0, 40);
    check("b2b_valid_count", valid_cnt - v0, 2);
    check("b2b_last_edge", last_valid_edge - e0, 78);
    check("b2b_no_ferr", err_cnt - f0, 0);
    if (valid_vals.size() >= q0 + 2) begin
      check("b2b_first", {24'd0, valid_vals[q0]}, 32'h3C);
      check("b2b_second", {24'd0, valid_vals[q0+1]}, 32'hC3);
    end else begin
      check("b2b_pulses_seen", valid_vals.size() - q0, 2);
    end
    check("b2b_dout", {24'd0, dout}, 32'hC3);

    // Reset during data bit 4 of a 0xFF-framed word
    v0 = valid_cnt; f0 = err_cnt;
    din = 1'b0;
    step(4);
    for (int k = 0; k < 4; k++) send_bit(1'b1);
    din = 1'b1;
    step(1);
    check("rst_mid_busy_before", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("rst_mid_dout", {24'd0, dout}, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'h0);
    check("rst_mid_valid", {31'd0, dout_valid}, 32'h0);
    check("rst_mid_ferr", {31'd0, frame_err}, 32'h0);
    step(50);
    check("rst_mid_no_valid", valid_cnt - v0, 0);
    check("rst_mid_no_ferr", err_cnt - f0, 0);
    send_frame(8'h5A, 1'b1, e0);
    step(5);
    check("post_rst_valid", valid_cnt - v0, 1);
    check("post_rst_edge", last_valid_edge - e0, 38);
    check("post_rst_dout", {24'd0, dout}, 32'h5A);

    // Idle line for 100 cycles
    v0 = valid_cnt; f0 = err_cnt; b0 = busy_cnt;
    din = 1'b1;
    step(100);
    check("idle_busy", busy_cnt - b0, 0);
    check("idle_valid", valid_cnt - v0, 0);
    check("idle_ferr", err_cnt - f0, 0);
    check("idle_dout", {24'd0, dout}, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
